// File: rtl/vdc_iter_32bit.sv
// vdc_iter_32bit: iterative van der Corput generator for one Halton dimension.
// Each CALC cycle strips one base-BASE digit from k and adds that digit at its
// mirrored position, so the result is vdc(k) scaled by BASE^SCALE.
module vdc_iter_32bit #(
  parameter int BASE  = 2,
  parameter int SCALE = 11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_k,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_vdc,
  output logic [31:0] out_k,
  input  logic        out_ready,
  output logic        busy
);

  // BASE^SCALE, saturated just above 32 bits so an oversized setting is caught.
  function automatic logic [63:0] powSat(input int b, input int e);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < e; i++) begin
      p = p * 64'(b);
      if (p > 64'hFFFF_FFFF) p = 64'h1_0000_0000;
    end
    return p;
  endfunction

  localparam logic [63:0] FACTOR_FULL = powSat(BASE, SCALE);
  localparam logic [31:0] FACTOR_INIT = FACTOR_FULL[31:0];
  localparam logic [31:0] BASE_W      = 32'(BASE);
  localparam logic [5:0]  SCALE_W     = 6'(SCALE);

  // Refuse to build a configuration whose scaled result would not fit 32 bits.
  if (BASE < 2 || BASE > 16 || SCALE < 1 || FACTOR_FULL > 64'hFFFF_FFFF) begin : g_param_check
    $error("vdc_iter_32bit: illegal BASE/SCALE combination");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] k_q, k_d;
  logic [31:0] factor_q, factor_d;
  logic [31:0] acc_q, acc_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] vdc_q, vdc_d;
  logic [31:0] kout_q, kout_d;

  logic [31:0] digit;
  logic [31:0] k_next;
  logic [31:0] factor_next;
  logic [31:0] acc_next;
  logic [5:0]  cnt_next;
  logic        calc_last;
  logic        accept;

  // One digit step: peel the lowest digit and weight it by the shrunken factor.
  always_comb begin
    digit       = k_q % BASE_W;
    k_next      = k_q / BASE_W;
    factor_next = factor_q / BASE_W;
    acc_next    = acc_q + digit * factor_next;
    cnt_next    = cnt_q + 6'd1;
    calc_last   = (k_next == 32'd0) || (cnt_next == SCALE_W);
    accept      = (state_q == IDLE) && in_valid;
  end

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      k_q      <= '0;
      factor_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      vdc_q    <= '0;
      kout_q   <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      factor_q <= factor_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      vdc_q    <= vdc_d;
      kout_q   <= kout_d;
    end
  end

  // Next-state logic: a zero index skips CALC, digits run out or hit SCALE to finish.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_k == 32'd0) ? DONE : CALC;
      CALC: if (calc_last) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; results only change on accept or on the final digit.
  always_comb begin
    k_d      = k_q;
    factor_d = factor_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    vdc_d    = vdc_q;
    kout_d   = kout_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          k_d      = in_k;
          kout_d   = in_k;
          factor_d = FACTOR_INIT;
          acc_d    = '0;
          cnt_d    = '0;
          if (in_k == 32'd0) vdc_d = '0;
        end
      end
      CALC: begin
        k_d      = k_next;
        factor_d = factor_next;
        acc_d    = acc_next;
        cnt_d    = cnt_next;
        if (calc_last) vdc_d = acc_next;
      end
      default: ;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign out_vdc = vdc_q;
  assign out_k   = kout_q;

endmodule

// File: tb/tb_vdc_iter_32bit.sv
// tb_vdc_iter_32bit: drives two configurations (base 2 / scale 11 and
// base 3 / scale 7) with directed and random indices and checks results,
// latency, handshake and reset against a digit-sum reference model.
module tb_vdc_iter_32bit;

  logic        clk;
  logic        rst_n;
  logic        inValid  [2];
  logic [31:0] inK      [2];
  logic        inReady  [2];
  logic        outValid [2];
  logic [31:0] outVdc   [2];
  logic [31:0] outK     [2];
  logic        outReady [2];
  logic        busy     [2];

  int checks;
  int failures;

  vdc_iter_32bit #(.BASE(2), .SCALE(11)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[0]), .in_k(inK[0]), .in_ready(inReady[0]),
    .out_valid(outValid[0]), .out_vdc(outVdc[0]), .out_k(outK[0]),
    .out_ready(outReady[0]), .busy(busy[0])
  );

  vdc_iter_32bit #(.BASE(3), .SCALE(7)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(inValid[1]), .in_k(inK[1]), .in_ready(inReady[1]),
    .out_valid(outValid[1]), .out_vdc(outVdc[1]), .out_k(outK[1]),
    .out_ready(outReady[1]), .busy(busy[1])
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int unitBase(input int u);
    return (u == 0) ? 2 : 3;
  endfunction

  function automatic int unitScale(input int u);
    return (u == 0) ? 11 : 7;
  endfunction

  // Reference: sum of digit_i * b^(s-1-i) over the first s digits of k.
  function automatic longint vdcRef(input longint k, input int b, input int s);
    longint acc, w, kk;
    acc = 0;
    kk  = k;
    for (int i = 0; i < s; i++) begin
      w = 1;
      for (int j = 0; j < s - 1 - i; j++) w = w * b;
      acc = acc + (kk % b) * w;
      kk  = kk / b;
    end
    return acc;
  endfunction

  // Edges after the accept edge until out_valid: zero index finishes on the
  // accept edge itself, otherwise one edge per digit capped at the scale.
  function automatic int latRef(input longint k, input int b, input int s);
    int n;
    longint kk;
    n  = 0;
    kk = k;
    while (kk > 0) begin
      n++;
      kk = kk / b;
    end
    return (n < s) ? n : s;
  endfunction

  task automatic checkOutput(input string tag, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // One full transaction on unit u: accept, wait, hold in DONE, release.
  task automatic applyStimulus(input int u, input logic [31:0] k, input longint expVdc, input int hold);
    int edges;
    longint expLat;
    expLat = latRef(longint'(k), unitBase(u), unitScale(u));
    @(negedge clk);
    checkOutput("in_ready before accept", longint'(inReady[u]), 1);
    inValid[u] = 1'b1;
    inK[u]     = k;
    @(posedge clk);
    #1;
    inValid[u] = 1'b0;
    inK[u]     = $urandom;
    edges = 0;
    while (outValid[u] !== 1'b1 && edges < 100) begin
      @(posedge clk);
      #1;
      edges++;
    end
    checkOutput("result timeout", longint'(edges < 100), 1);
    checkOutput("latency", edges, expLat);
    checkOutput("out_vdc", longint'(outVdc[u]), expVdc);
    checkOutput("out_k", longint'(outK[u]), longint'(k));
    checkOutput("busy in DONE", longint'(busy[u]), 1);
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      inValid[u] = 1'($urandom % 2);
      inK[u]     = $urandom;
      @(posedge clk);
      #1;
      checkOutput("hold out_valid", longint'(outValid[u]), 1);
      checkOutput("hold out_vdc", longint'(outVdc[u]), expVdc);
      checkOutput("hold in_ready", longint'(inReady[u]), 0);
    end
    @(negedge clk);
    outReady[u] = 1'b1;
    inValid[u]  = 1'b1;
    inK[u]      = 32'd7;
    @(posedge clk);
    #1;
    checkOutput("release out_valid", longint'(outValid[u]), 0);
    checkOutput("release in_ready", longint'(inReady[u]), 1);
    checkOutput("release busy", longint'(busy[u]), 0);
    checkOutput("idle out_vdc kept", longint'(outVdc[u]), expVdc);
    checkOutput("idle out_k kept", longint'(outK[u]), longint'(k));
    @(negedge clk);
    outReady[u] = 1'b0;
    inValid[u]  = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    for (int u = 0; u < 2; u++) begin
      inValid[u]  = 1'b0;
      inK[u]      = '0;
      outReady[u] = 1'b0;
    end
    #12;
    for (int u = 0; u < 2; u++) begin
      checkOutput("reset out_valid", longint'(outValid[u]), 0);
      checkOutput("reset busy", longint'(busy[u]), 0);
      checkOutput("reset in_ready", longint'(inReady[u]), 1);
      checkOutput("reset out_vdc", longint'(outVdc[u]), 0);
      checkOutput("reset out_k", longint'(outK[u]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors, base 2 scale 11.
    applyStimulus(0, 32'd1, 1024, 0);
    applyStimulus(0, 32'd2, 512, 0);
    applyStimulus(0, 32'd3, 1536, 0);
    applyStimulus(0, 32'd5, 1280, 0);
    applyStimulus(0, 32'd0, 0, 1);
    applyStimulus(0, 32'd2048, 0, 0);
    applyStimulus(0, 32'hFFFF_FFFF, 2047, 5);

    // Directed vectors, base 3 scale 7.
    applyStimulus(1, 32'd1, 729, 0);
    applyStimulus(1, 32'd2, 1458, 0);
    applyStimulus(1, 32'd3, 243, 0);
    applyStimulus(1, 32'd5, 1701, 0);
    applyStimulus(1, 32'd0, 0, 2);

    // Asynchronous reset in the middle of a base-2 computation of k=5.
    @(negedge clk);
    inValid[0] = 1'b1;
    inK[0]     = 32'd5;
    @(posedge clk);
    #1;
    inValid[0] = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("busy before reset", longint'(busy[0]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset out_valid", longint'(outValid[0]), 0);
    checkOutput("async reset busy", longint'(busy[0]), 0);
    checkOutput("async reset in_ready", longint'(inReady[0]), 1);
    checkOutput("async reset out_vdc", longint'(outVdc[0]), 0);
    checkOutput("async reset out_k", longint'(outK[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 32'd3, 1536, 0);

    // Random indices on both units, mixing small, full-width and power values.
    for (int n = 0; n < 60; n++) begin
      int u;
      logic [31:0] k;
      u = n % 2;
      case ($urandom % 3)
        0: k = $urandom_range(0, 100);
        1: k = $urandom;
        default: k = 32'd1 << ($urandom % 32);
      endcase
      applyStimulus(u, k, vdcRef(longint'(k), unitBase(u), unitScale(u)), int'($urandom % 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
